psum_fifo: RTL and testbench

//  Circular partial-sum buffer between the adder-tree output and its fifo_data input.

---
 rtl/psum_fifo.sv | 101 ++++++++++
 tb/tb_psum_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_fifo.sv
// Circular partial-sum buffer between the adder-tree output and its fifo_data input.
// Zero-read mode returns 0 without popping so the first channel group starts from nothing.
module psum_fifo #(
  parameter int DATA_WIDTH = 25,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  input  logic                         rd_zero,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic        [ADDR_WIDTH:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic        [ADDR_WIDTH-1:0] r_wr_ptr;
  logic        [ADDR_WIDTH-1:0] r_rd_ptr;
  logic        [ADDR_WIDTH:0]   r_count;
  logic signed [DATA_WIDTH-1:0] r_rd_data;
  logic                         r_rd_valid;
  logic                         r_overflow;
  logic                         r_underflow;

  logic w_flush;
  logic w_pop;
  logic w_zero_rd;
  logic w_rd_reject;
  logic w_push;
  logic w_wr_reject;

  assign full  = (r_count == LP_DEPTH);
  assign empty = (r_count == '0);

  // Flush gates every acceptance so reset/clear always win over traffic.
  assign w_flush     = !rst_n || clear;
  assign w_pop       = !w_flush && rd_en && !rd_zero && !empty;
  assign w_zero_rd   = !w_flush && rd_en && rd_zero;
  assign w_rd_reject = !w_flush && rd_en && !rd_zero && empty;
  assign w_push      = !w_flush && wr_en && (!full || w_pop);
  assign w_wr_reject = !w_flush && wr_en && !(!full || w_pop);

  // Storage is never reset; a push at full only happens alongside a pop,
  // and the nonblocking read below still sees the old word at that slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid <= w_pop || w_zero_rd;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
      end else if (w_zero_rd) begin
        r_rd_data <= '0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (ADDR_WIDTH+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (ADDR_WIDTH+1)'(1);
      end
      if (w_wr_reject) begin
        r_overflow <= 1'b1;
      end
      if (w_rd_reject) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_psum_fifo.sv
// Directed bench for psum_fifo: each task drives one scenario and checks inline.
module tb_psum_fifo;
  localparam int DW = 25;
  localparam int AW = 6;

  logic                 clk;
  logic                 rst_n;
  logic                 clear;
  logic                 wr_en;
  logic signed [DW-1:0] wr_data;
  logic                 rd_en;
  logic                 rd_zero;
  logic signed [DW-1:0] rd_data;
  logic                 rd_valid;
  logic                 full;
  logic                 empty;
  logic [AW:0]          count;
  logic                 overflow;
  logic                 underflow;

  int errors = 0;
  int checks = 0;

  psum_fifo #(.DATA_WIDTH(DW), .DEPTH(64), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_zero(rd_zero), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given inputs held; returns 1 time unit after the edge with inputs idle.
  task automatic cyc(input logic w, input logic signed [DW-1:0] d, input logic r, input logic z);
    wr_en = w; wr_data = d; rd_en = r; rd_zero = z;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; rd_zero = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    checks++;
    if (count !== 7'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 ||
        rd_data !== 25'sd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d empty=%b full=%b vld=%b data=%0d ovf=%b unf=%b, want 0 1 0 0 0 0 0",
               count, empty, full, rd_valid, rd_data, overflow, underflow);
    end
    $display("reset: count=%0d empty=%b", count, empty);
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] exp_v [3];
    exp_v[0] = 25'sd5; exp_v[1] = -25'sd3; exp_v[2] = 25'sd7;
    for (int i = 0; i < 3; i++) cyc(1'b1, exp_v[i], 1'b0, 1'b0);
    checks++;
    if (count !== 7'd3) begin
      errors++; $display("FAIL basic_count: got %0d want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rd_data !== exp_v[i] || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_read%0d: data=%0d vld=%b want %0d 1", i, rd_data, rd_valid, exp_v[i]);
      end
      $display("basic read %0d: data=%0d vld=%b", i, rd_data, rd_valid);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 25'sd7 || count !== 7'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: vld=%b data=%0d count=%0d empty=%b want 0 7 0 1",
               rd_valid, rd_data, count, empty);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 64; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 7'd64 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d ovf=%b want 1 64 0", full, count, overflow);
    end
    cyc(1'b1, 25'sd1000, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 7'd64) begin
      errors++; $display("FAIL overflow: ovf=%b count=%0d want 1 64", overflow, count);
    end
    $display("overflow write: ovf=%b count=%0d", overflow, count);
    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rd_data !== DW'(i) || rd_valid !== 1'b1) begin
        errors++; $display("FAIL wrap_read%0d: data=%0d vld=%b want %0d 1", i, rd_data, rd_valid, i);
      end
    end
    $display("wrap drain: last=%0d count=%0d", rd_data, count);
    checks++;
    if (empty !== 1'b1 || count !== 7'd0 || overflow !== 1'b1) begin
      errors++; $display("FAIL wrap_empty: empty=%b count=%0d ovf=%b want 1 0 1", empty, count, overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 0; i < 64; i++) cyc(1'b1, DW'(100 + i), 1'b0, 1'b0);
    cyc(1'b1, 25'sd99, 1'b1, 1'b0);
    checks++;
    if (rd_data !== 25'sd100 || count !== 7'd64 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full: data=%0d count=%0d ovf=%b full=%b want 100 64 0 1",
               rd_data, count, overflow, full);
    end
    $display("b2b at full: data=%0d count=%0d", rd_data, count);
    for (int i = 1; i < 64; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rd_data !== DW'(100 + i)) begin
        errors++; $display("FAIL b2b_read%0d: data=%0d want %0d", i, rd_data, 100 + i);
      end
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rd_data !== 25'sd99 || count !== 7'd0) begin
      errors++; $display("FAIL b2b_last: data=%0d count=%0d want 99 0", rd_data, count);
    end
    $display("b2b last: data=%0d count=%0d", rd_data, count);
  endtask

  task automatic test_zero_read();
    do_clear();
    cyc(1'b1, 25'sd42, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (rd_data !== 25'sd0 || rd_valid !== 1'b1 || count !== 7'd0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_read: data=%0d vld=%b count=%0d unf=%b want 0 1 0 0",
               rd_data, rd_valid, count, underflow);
    end
    $display("zero read: data=%0d vld=%b", rd_data, rd_valid);
    cyc(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 25'sd0) begin
      errors++;
      $display("FAIL underflow: unf=%b vld=%b data=%0d want 1 0 0", underflow, rd_valid, rd_data);
    end
    $display("rejected read: unf=%b vld=%b", underflow, rd_valid);
    // Zero-read while holding data must not pop it.
    cyc(1'b1, 25'sd11, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (count !== 7'd1 || rd_data !== 25'sd0) begin
      errors++; $display("FAIL zero_nopop: count=%0d data=%0d want 1 0", count, rd_data);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rd_data !== 25'sd11 || count !== 7'd0) begin
      errors++; $display("FAIL zero_then_pop: data=%0d count=%0d want 11 0", rd_data, count);
    end
  endtask

  task automatic test_flush(input bit use_rst);
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(20 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    if (use_rst) rst_n = 1'b0; else clear = 1'b1;
    cyc(1'b1, 25'sd77, 1'b1, 1'b0);
    rst_n = 1'b1; clear = 1'b0;
    checks++;
    if (count !== 7'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
        rd_valid !== 1'b0 || rd_data !== 25'sd0) begin
      errors++;
      $display("FAIL flush%0d: count=%0d empty=%b ovf=%b unf=%b vld=%b data=%0d want 0 1 0 0 0 0",
               use_rst, count, empty, overflow, underflow, rd_valid, rd_data);
    end
    $display("flush(rst=%0d): count=%0d empty=%b", use_rst, count, empty);
    cyc(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL flush_ignored_wr%0d: vld=%b unf=%b want 0 1", use_rst, rd_valid, underflow);
    end
  endtask

  task automatic test_extremes();
    logic signed [DW-1:0] lo;
    logic signed [DW-1:0] hi;
    lo = 25'h1000000;
    hi = 25'h0FFFFFF;
    do_clear();
    cyc(1'b1, lo, 1'b0, 1'b0);
    cyc(1'b1, hi, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rd_data !== lo) begin
      errors++; $display("FAIL extreme_min: got %h want %h", rd_data, lo);
    end
    $display("extreme min: data=%0d", rd_data);
    cyc(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (rd_data !== hi) begin
      errors++; $display("FAIL extreme_max: got %h want %h", rd_data, hi);
    end
    $display("extreme max: data=%0d", rd_data);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rd_zero = 1'b0;
    test_reset();
    test_basic();
    test_fill_wrap();
    test_back_to_back();
    test_zero_read();
    test_flush(1'b0);
    test_flush(1'b1);
    test_extremes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
